mdv_mem_arbiter: RTL and testbench

// Shares the single SDRAM read port between the two microdrive emulators (MDV1_, MDV2_).

---
 rtl/mdv_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mdv_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdv_mem_arbiter.sv
// Arbitrates the shared SDRAM read port between the two microdrive emulators.
// One word read in flight at a time, issued only in non-video slots.
module mdv_mem_arbiter #(
   parameter int unsigned AW     = 25,
   parameter int unsigned DW     = 16,
   parameter int unsigned RD_LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          mem_ena,
   input  logic          video_cyc,
   input  logic          pref,
   input  logic          req0,
   input  logic          req1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   output logic          ack0,
   output logic          ack1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   input  logic [DW-1:0] mem_din,
   output logic          busy
);

   localparam int unsigned CW = 3;
   localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_CAPT
   } state_t;

   state_t          state, state_d;
   logic [CW-1:0]   cnt, cnt_d;
   logic            owner, owner_d;
   logic            contended, contended_d;
   logic            last, last_d;
   logic [1:0]      streak, streak_d;
   logic            win;
   logic            ack0_d, ack1_d, rvalid0_d, rvalid1_d, mem_rd_d, busy_d;
   logic [AW-1:0]   mem_addr_d;
   logic [DW-1:0]   rdata_d;

   // Next state and next registered outputs
   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      owner_d     = owner;
      contended_d = contended;
      last_d      = last;
      streak_d    = streak;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      rvalid0_d   = 1'b0;
      rvalid1_d   = 1'b0;
      mem_rd_d    = 1'b0;
      busy_d      = busy;
      mem_addr_d  = mem_addr;
      rdata_d     = rdata;
      win         = 1'b0;

      case (state)
         S_IDLE: begin
            // A requester that took two contended grants in a row yields to the other
            if (req0 && req1) begin
               win = (streak >= 2'd2) ? ~last : pref;
            end else begin
               win = req1;
            end
            if (mem_ena && !video_cyc && (req0 || req1)) begin
               mem_rd_d    = 1'b1;
               mem_addr_d  = win ? addr1 : addr0;
               ack0_d      = ~win;
               ack1_d      = win;
               owner_d     = win;
               contended_d = req0 & req1;
               cnt_d       = '0;
               busy_d      = 1'b1;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt == CNT_LAST) begin
               state_d = S_CAPT;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         S_CAPT: begin
            rdata_d   = mem_din;
            rvalid0_d = ~owner;
            rvalid1_d = owner;
            busy_d    = 1'b0;
            last_d    = owner;
            if (!contended) begin
               streak_d = 2'd0;
            end else if (owner == last) begin
               streak_d = (streak == 2'd3) ? streak : streak + 2'd1;
            end else begin
               streak_d = 2'd1;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         owner     <= 1'b0;
         contended <= 1'b0;
         last      <= 1'b1;
         streak    <= 2'd0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
         mem_rd    <= 1'b0;
         busy      <= 1'b0;
         mem_addr  <= '0;
         rdata     <= '0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         owner     <= owner_d;
         contended <= contended_d;
         last      <= last_d;
         streak    <= streak_d;
         ack0      <= ack0_d;
         ack1      <= ack1_d;
         rvalid0   <= rvalid0_d;
         rvalid1   <= rvalid1_d;
         mem_rd    <= mem_rd_d;
         busy      <= busy_d;
         mem_addr  <= mem_addr_d;
         rdata     <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mdv_mem_arbiter.sv
// Self-checking bench for mdv_mem_arbiter: directed scenarios plus randomized
// traffic against a grant/latency model built from the arbitration rules.
module tb_mdv_mem_arbiter;

   localparam int unsigned AW     = 25;
   localparam int unsigned DW     = 16;
   localparam int unsigned RD_LAT = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          mem_ena = 1'b0;
   logic          video_cyc = 1'b0;
   logic          pref = 1'b0;
   logic          req0 = 1'b0;
   logic          req1 = 1'b0;
   logic [AW-1:0] addr0 = '0;
   logic [AW-1:0] addr1 = '0;
   logic [DW-1:0] mem_din;
   logic          ack0, ack1, rvalid0, rvalid1, mem_rd, busy;
   logic [DW-1:0] rdata;
   logic [AW-1:0] mem_addr;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   mdv_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(reset), .mem_ena(mem_ena), .video_cyc(video_cyc),
      .pref(pref), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_din(mem_din),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
      return DW'(a) ^ DW'(a >> 9) ^ 16'hA5C3;
   endfunction

   // SDRAM model: data for the strobed address is valid RD_LAT cycles after mem_rd
   int            mk = 100;
   logic [AW-1:0] mem_a = '0;
   always @(posedge clk) begin
      #2;
      if (mem_rd) begin
         mem_a = mem_addr;
         mk    = 0;
      end else if (mk < 100) begin
         mk++;
      end
      mem_din = (mk == int'(RD_LAT)) ? data_of(mem_a) : DW'($urandom);
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      reset = 1'b1; mem_ena = 1'b1; req0 = 1'b1; addr0 = 25'h0_0abc;
      tick(); tick();
      total++;
      if ({ack0, ack1, rvalid0, rvalid1, mem_rd, busy} !== 6'b0) begin
         bad++; $display("FAIL reset_ctl: got=%b want=000000", {ack0, ack1, rvalid0, rvalid1, mem_rd, busy});
      end
      total++;
      if (mem_addr !== '0 || rdata !== '0) begin
         bad++; $display("FAIL reset_data: mem_addr=%h rdata=%h want 0/0", mem_addr, rdata);
      end
      req0 = 1'b0; reset = 1'b0;
      tick();
   endtask

   task automatic test_single();
      for (int i = 0; i < 4; i++) begin
         logic          n;
         logic [AW-1:0] a;
         logic [1:0]    oh;
         n  = i[0];
         a  = (i == 0) ? 25'h0_1234 : AW'($urandom);
         oh = n ? 2'b10 : 2'b01;
         if (n) begin req1 = 1'b1; addr1 = a; end
         else   begin req0 = 1'b1; addr0 = a; end
         tick();
         total++;
         if ({ack1, ack0} !== oh || mem_rd !== 1'b1 || mem_addr !== a) begin
            bad++; $display("FAIL single_issue[%0d]: ack=%b rd=%b addr=%h want ack=%b rd=1 addr=%h", i, {ack1, ack0}, mem_rd, mem_addr, oh, a);
         end
         req0 = 1'b0; req1 = 1'b0;
         tick();
         total++;
         if (mem_rd !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL single_wait[%0d]: rd=%b busy=%b want 0/1", i, mem_rd, busy);
         end
         tick();
         tick();
         total++;
         if ({rvalid1, rvalid0} !== oh || rdata !== data_of(a) || busy !== 1'b0) begin
            bad++; $display("FAIL single_data[%0d]: rv=%b rdata=%h busy=%b want rv=%b rdata=%h busy=0", i, {rvalid1, rvalid0}, rdata, busy, oh, data_of(a));
         end
      end
   endtask

   task automatic test_pref();
      addr0 = AW'($urandom); addr1 = AW'($urandom);
      pref = 1'b1; req0 = 1'b1; req1 = 1'b1;
      tick();
      total++;
      if ({ack1, ack0} !== 2'b10) begin
         bad++; $display("FAIL pref_first: ack=%b want 10", {ack1, ack0});
      end
      req1 = 1'b0;
      tick(); tick(); tick();
      total++;
      if ({rvalid1, ack0} !== 2'b10 || rdata !== data_of(addr1)) begin
         bad++; $display("FAIL pref_rv1: rv1,ack0=%b rdata=%h want 10 %h", {rvalid1, ack0}, rdata, data_of(addr1));
      end
      tick();
      total++;
      if (ack0 !== 1'b1 || mem_addr !== addr0) begin
         bad++; $display("FAIL pref_second: ack0=%b addr=%h want 1 %h", ack0, mem_addr, addr0);
      end
      req0 = 1'b0;
      tick(); tick(); tick();
      total++;
      if (rvalid0 !== 1'b1 || rdata !== data_of(addr0)) begin
         bad++; $display("FAIL pref_rv0: rv0=%b rdata=%h want 1 %h", rvalid0, rdata, data_of(addr0));
      end
   endtask

   task automatic test_video();
      video_cyc = 1'b1; req0 = 1'b1; addr0 = AW'($urandom);
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (mem_rd !== 1'b0 || ack0 !== 1'b0) begin
            bad++; $display("FAIL video_block[%0d]: rd=%b ack0=%b want 0/0", i, mem_rd, ack0);
         end
      end
      video_cyc = 1'b0;
      tick();
      total++;
      if (mem_rd !== 1'b1 || ack0 !== 1'b1 || mem_addr !== addr0) begin
         bad++; $display("FAIL video_issue: rd=%b ack0=%b addr=%h want 1/1/%h", mem_rd, ack0, mem_addr, addr0);
      end
      req0 = 1'b0;
      tick(); tick(); tick();
      total++;
      if (rvalid0 !== 1'b1 || rdata !== data_of(addr0)) begin
         bad++; $display("FAIL video_data: rv0=%b rdata=%h want 1 %h", rvalid0, rdata, data_of(addr0));
      end
   endtask

   task automatic test_starve();
      int exp_order[6] = '{1, 1, 0, 1, 1, 0};
      reset = 1'b1;
      tick();
      reset = 1'b0; pref = 1'b1; mem_ena = 1'b1; video_cyc = 1'b0;
      addr0 = AW'($urandom); addr1 = AW'($urandom);
      req0 = 1'b1; req1 = 1'b1;
      for (int g = 0; g < 6; g++) begin
         int w   = 0;
         int got = -1;
         while (got < 0 && w < 10) begin
            tick();
            w++;
            if (ack0) got = 0;
            else if (ack1) got = 1;
         end
         total++;
         if (got != exp_order[g] || (g > 0 && w != int'(RD_LAT) + 2)) begin
            bad++; $display("FAIL starve_grant[%0d]: winner=%0d gap=%0d want winner=%0d gap=%0d", g, got, w, exp_order[g], (g > 0) ? int'(RD_LAT) + 2 : 1);
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (5) tick();
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      req0 = 1'b1; addr0 = AW'($urandom);
      tick();
      total++;
      if (ack0 !== 1'b1) begin
         bad++; $display("FAIL rstmid_ack: ack0=%b want 1", ack0);
      end
      req0 = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      total++;
      if ({ack0, ack1, rvalid0, rvalid1, mem_rd, busy} !== 6'b0 || rdata !== '0) begin
         bad++; $display("FAIL rstmid_state: ctl=%b rdata=%h want 000000 0", {ack0, ack1, rvalid0, rvalid1, mem_rd, busy}, rdata);
      end
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rvalid0 || rvalid1) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++; $display("FAIL rstmid_norv: rvalid pulses=%0d want 0", seen);
      end
      req1 = 1'b1; addr1 = AW'($urandom);
      tick();
      total++;
      if (ack1 !== 1'b1 || mem_addr !== addr1) begin
         bad++; $display("FAIL rstmid_reissue: ack1=%b addr=%h want 1 %h", ack1, mem_addr, addr1);
      end
      req1 = 1'b0;
      tick(); tick(); tick();
      total++;
      if (rvalid1 !== 1'b1 || rdata !== data_of(addr1)) begin
         bad++; $display("FAIL rstmid_data: rv1=%b rdata=%h want 1 %h", rvalid1, rdata, data_of(addr1));
      end
   endtask

   task automatic test_mem_ena();
      mem_ena = 1'b0; req0 = 1'b1; addr0 = AW'($urandom);
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (mem_rd !== 1'b0 || ack0 !== 1'b0) begin
            bad++; $display("FAIL ena_block[%0d]: rd=%b ack0=%b want 0/0", i, mem_rd, ack0);
         end
      end
      mem_ena = 1'b1;
      tick();
      total++;
      if (ack0 !== 1'b1 || mem_rd !== 1'b1) begin
         bad++; $display("FAIL ena_issue: ack0=%b rd=%b want 1/1", ack0, mem_rd);
      end
      mem_ena = 1'b0; req0 = 1'b0;
      tick(); tick(); tick();
      total++;
      if (rvalid0 !== 1'b1 || rdata !== data_of(addr0)) begin
         bad++; $display("FAIL ena_inflight: rv0=%b rdata=%h want 1 %h", rvalid0, rdata, data_of(addr0));
      end
      mem_ena = 1'b1;
      tick();
   endtask

   // Random traffic against a model: one read per RD_LAT+2 slots, rvalid RD_LAT+1 after ack,
   // pref on contention unless the same side took the last two contended grants.
   task automatic test_random();
      logic          rq[2];
      logic [AW-1:0] ad[2];
      logic [1:0]    e_ack, e_rv;
      logic          e_rd, e_busy, both, w;
      logic [AW-1:0] e_addr, paddr;
      logic          pown, h1w, h1c, h2w, h2c;
      int            free, due;
      rq[0] = 1'b0; rq[1] = 1'b0; ad[0] = '0; ad[1] = '0;
      req0 = 1'b0; req1 = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      free = cyc; due = -1; pown = 1'b0; paddr = '0;
      h1w = 1'b1; h1c = 1'b0; h2w = 1'b1; h2c = 1'b0;
      e_ack = '0; e_rv = '0; e_rd = 1'b0; e_busy = 1'b0; e_addr = '0;
      for (int it = 0; it < 400; it++) begin
         total++;
         if ({ack1, ack0, rvalid1, rvalid0, mem_rd, busy} !== {e_ack, e_rv, e_rd, e_busy}) begin
            bad++; $display("FAIL rnd_ctl cyc=%0d: ack,rv,rd,busy got=%b want=%b", cyc, {ack1, ack0, rvalid1, rvalid0, mem_rd, busy}, {e_ack, e_rv, e_rd, e_busy});
         end
         if (e_rd) begin
            total++;
            if (mem_addr !== e_addr) begin
               bad++; $display("FAIL rnd_addr cyc=%0d: got=%h want=%h", cyc, mem_addr, e_addr);
            end
         end
         if (|e_rv) begin
            total++;
            if (rdata !== data_of(paddr)) begin
               bad++; $display("FAIL rnd_data cyc=%0d: got=%h want=%h", cyc, rdata, data_of(paddr));
            end
         end
         for (int n = 0; n < 2; n++) begin
            if (e_ack[n]) begin
               rq[n] = 1'($urandom_range(0, 1));
               ad[n] = AW'($urandom);
            end else if (!rq[n] && $urandom_range(0, 2) == 0) begin
               rq[n] = 1'b1;
               ad[n] = AW'($urandom);
            end
         end
         req0 = rq[0]; req1 = rq[1]; addr0 = ad[0]; addr1 = ad[1];
         mem_ena   = ($urandom_range(0, 9) != 0);
         video_cyc = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) pref = ~pref;
         e_ack = '0; e_rv = '0; e_rd = 1'b0;
         if (cyc + 1 == due) e_rv[pown] = 1'b1;
         if (cyc >= free && mem_ena && !video_cyc && (rq[0] || rq[1])) begin
            both = rq[0] & rq[1];
            if (both) w = (h1c && h2c && h1w == h2w) ? ~h1w : pref;
            else      w = rq[1];
            e_ack[w] = 1'b1;
            e_rd     = 1'b1;
            e_addr   = ad[w];
            due      = cyc + 1 + int'(RD_LAT) + 1;
            free     = due;
            pown     = w;
            paddr    = ad[w];
            h2w = h1w; h2c = h1c; h1w = w; h1c = both;
         end
         e_busy = (cyc + 1 < free);
         tick();
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (6) tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_pref();
      test_video();
      test_starve();
      test_reset_mid();
      test_mem_ena();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
